// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: queues single-precision requests and drives them one at a time through the fpu operand/result handshake
module fpu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       fpu_funct,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_o,
  input  logic             fpu_finish,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [1:0]       resp_funct,
  output logic             resp_timeout,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = 2 + 64 + TAG_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] tmo_cnt;
  logic [TAG_W-1:0] held_tag;
  logic finish_q, push, pop, finish_rise, expired;
  // command storage needs no reset: an entry is always written before it is read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_funct, req_a, req_b, req_tag};
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: a rising finish beats an expiring counter; finish is ignored while operands settle in ISSUE
  always_comb begin
    finish_rise = fpu_finish && !finish_q;
    expired = tmo_cnt == CW'(TIMEOUT);
    state_nx = pop ? ISSUE :
               (state == ISSUE) ? WAIT :
               (state == WAIT && (finish_rise || expired)) ? RESP :
               (state == RESP && resp_valid && resp_ready) ? IDLE : state;
  end
  // handshake and status outputs; a new op launches only once the previous response is gone
  always_comb begin
    req_ready = count < (AW+1)'(DEPTH);
    push = req_valid && req_ready;
    pop = state == IDLE && count != '0 && !resp_valid;
    busy = state != IDLE || count != '0;
  end
  // fifo pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // operand launch, wait counter, finish edge detect and response capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fpu_funct <= '0;
      fpu_a <= '0;
      fpu_b <= '0;
      held_tag <= '0;
      finish_q <= 1'b0;
      tmo_cnt <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_tag <= '0;
      resp_funct <= '0;
      resp_timeout <= 1'b0;
    end else begin
      finish_q <= fpu_finish;
      if (pop) {fpu_funct, fpu_a, fpu_b, held_tag} <= mem[rd_ptr];
      if (state == ISSUE) tmo_cnt <= '0;
      else if (state == WAIT && !finish_rise && !expired) tmo_cnt <= tmo_cnt + CW'(1);
      if (state == WAIT && (finish_rise || expired)) begin
        resp_valid <= 1'b1;
        resp_data <= finish_rise ? fpu_o : '0;
        resp_tag <= held_tag;
        resp_funct <= fpu_funct;
        resp_timeout <= !finish_rise;
      end else if (resp_valid && resp_ready) resp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed and random stimulus checked every cycle against a queue-based transaction model
module tb_fpu_op_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO = 15;
  logic clk = 0, reset = 0;
  logic req_valid = 0, fpu_finish = 0, resp_ready = 0;
  logic [1:0] req_funct = 0;
  logic [31:0] req_a = 0, req_b = 0, fpu_o = 0;
  logic [3:0] req_tag = 0;
  logic req_ready, resp_valid, resp_timeout, busy;
  logic [1:0] fpu_funct, resp_funct;
  logic [31:0] fpu_a, fpu_b, resp_data;
  logic [3:0] resp_tag;
  int checks = 0, errors = 0;
  int fmode = 3, flat = 1, rnd_div = 2;
  typedef struct packed {logic [1:0] f; logic [31:0] a; logic [31:0] b; logic [3:0] t;} req_t;
  req_t q[$];
  req_t cur = '0;
  bit inflight = 0, rv = 0, m_to = 0, m_prev = 0;
  int age = 0;
  logic [31:0] m_data = 0;
  logic [3:0] m_tag = 0;
  logic [1:0] m_funct = 0;

  fpu_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_funct(fpu_funct), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_o(fpu_o), .fpu_finish(fpu_finish),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_funct(resp_funct), .resp_timeout(resp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // transaction model: queue of pending requests, one op in flight aged from its issue cycle, one held response
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      cur = '0; inflight = 0; age = 0; rv = 0; m_to = 0; m_prev = 0;
      m_data = 0; m_tag = 0; m_funct = 0;
    end else begin : step
      bit rise, pop_now, push_now;
      rise = fpu_finish && !m_prev;
      m_prev = fpu_finish;
      push_now = req_valid && q.size() < DEPTH;
      pop_now = !inflight && !rv && q.size() > 0;
      if (rv && resp_ready) rv = 0;
      else if (inflight) begin
        if (age == 0) age = 1;
        else if (rise) begin inflight = 0; rv = 1; m_data = fpu_o; m_tag = cur.t; m_funct = cur.f; m_to = 0; end
        else if (age - 1 == TMO) begin inflight = 0; rv = 1; m_data = 0; m_tag = cur.t; m_funct = cur.f; m_to = 1; end
        else age++;
      end
      if (pop_now) begin cur = q.pop_front(); inflight = 1; age = 0; end
      if (push_now) q.push_back({req_funct, req_a, req_b, req_tag});
    end
  end

  // fpu stand-in: 0 pulse at age flat, 1 level that stays high between ops, 2 random, 3 never finishes
  always @(negedge clk) begin
    fpu_finish = fmode == 0 ? (inflight && age == flat) :
                 fmode == 1 ? (!inflight ? fpu_finish : (age <= 1 ? 1'b1 : age >= 3)) :
                 fmode == 2 ? ($urandom_range(0, rnd_div) == 0) : 1'b0;
    fpu_o = (fpu_a == 32'h3F800000 && fpu_b == 32'h40000000) ? 32'h40400000 :
            fpu_a ^ {fpu_b[15:0], fpu_b[31:16]} ^ {30'd0, fpu_funct};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(inflight || rv || q.size() != 0));
    chk("resp_valid", 32'(resp_valid), 32'(rv));
    chk("fpu_funct", 32'(fpu_funct), 32'(cur.f));
    chk("fpu_a", fpu_a, cur.a);
    chk("fpu_b", fpu_b, cur.b);
    if (rv) begin
      chk("resp_data", resp_data, m_data);
      chk("resp_tag", 32'(resp_tag), 32'(m_tag));
      chk("resp_funct", 32'(resp_funct), 32'(m_funct));
      chk("resp_timeout", 32'(resp_timeout), 32'(m_to));
    end
  end

  task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_funct = f; req_a = a; req_b = b; req_tag = t;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("send_accept", 32'(n < 200), 1);
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("resp_arrives", 32'(resp_valid), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || resp_valid) && n < 400) begin @(posedge clk); #1; n++; end
    chk("drain_idle", 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic collect(input int cnt, input int tag0);
    int got = 0, n = 0;
    while (got < cnt && n < 300) begin
      if (resp_valid) begin
        chk("order_tag", 32'(resp_tag), 32'(tag0 + got));
        chk("order_timeout", 32'(resp_timeout), 0);
        got++;
      end
      @(negedge clk);
      n++;
    end
    chk("order_count", 32'(got), 32'(cnt));
  endtask

  initial begin
    int n;
    #1 reset = 1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_resp_data", resp_data, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    fmode = 0; flat = 3; resp_ready = 1;
    send(2'b00, 32'h3F800000, 32'h40000000, 4'd5);
    wait_resp(n);
    chk("add_latency", 32'(n), 5);
    chk("add_data", resp_data, 32'h40400000);
    chk("add_tag", 32'(resp_tag), 5);
    chk("add_funct", 32'(resp_funct), 0);
    chk("add_timeout", 32'(resp_timeout), 0);
    wait_idle();
    resp_ready = 0; flat = 2;
    for (int i = 0; i < 5; i++) send(2'(i), $urandom, $urandom, 4'(i));
    @(negedge clk);
    chk("full_ready", 32'(req_ready), 0);
    chk("full_busy", 32'(busy), 1);
    repeat (4) @(negedge clk);
    resp_ready = 1;
    collect(5, 0);
    wait_idle();
    fmode = 1;
    send(2'd1, 32'h0000000A, 32'h0000000B, 4'd7);
    send(2'd3, 32'h0000000C, 32'h0000000D, 4'd8);
    @(negedge clk);
    collect(2, 7);
    fmode = 0;
    wait_idle();
    fmode = 3;
    @(negedge clk);
    send(2'd1, 32'h11111111, 32'h22222222, 4'd9);
    send(2'd2, 32'h33333333, 32'h44444444, 4'd10);
    wait_resp(n);
    chk("timeout_latency", 32'(n), 17);
    chk("timeout_flag", 32'(resp_timeout), 1);
    chk("timeout_data", resp_data, 0);
    chk("timeout_tag", 32'(resp_tag), 9);
    fmode = 0; flat = 2;
    @(posedge clk);
    #1;
    wait_resp(n);
    chk("next_tag", 32'(resp_tag), 10);
    chk("next_timeout", 32'(resp_timeout), 0);
    wait_idle();
    flat = 16;
    send(2'd2, 32'h12345678, 32'h0000FFFF, 4'd3);
    wait_resp(n);
    chk("race_latency", 32'(n), 18);
    chk("race_timeout", 32'(resp_timeout), 0);
    chk("race_data", resp_data, 32'hEDCB567A);
    wait_idle();
    for (int ph = 0; ph < 2; ph++) begin
      fmode = 2; rnd_div = ph == 0 ? 2 : 24;
      repeat (300) begin
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1));
        req_funct = 2'($urandom);
        req_a = $urandom;
        req_b = $urandom;
        req_tag = 4'($urandom);
        resp_ready = $urandom_range(0, 3) != 0;
      end
    end
    @(negedge clk);
    req_valid = 0; resp_ready = 1; fmode = 0; flat = 1;
    wait_idle();
    fmode = 3;
    send(2'd1, 32'hDEADBEEF, 32'h00000001, 4'd1);
    send(2'd0, 32'h00000002, 32'h00000003, 4'd2);
    send(2'd0, 32'h00000004, 32'h00000005, 4'd3);
    @(negedge clk);
    chk("pre_reset_fpu_a", fpu_a, 32'hDEADBEEF);
    chk("pre_reset_busy", 32'(busy), 1);
    #2 reset = 1;
    #1;
    chk("ar_resp_valid", 32'(resp_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_req_ready", 32'(req_ready), 1);
    chk("ar_fpu_a", fpu_a, 0);
    @(negedge clk);
    reset = 0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid || busy) n++;
    end
    chk("no_stale_resp", 32'(n), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
